nv_nvdla_sdp_rdma_split: RTL and testbench

NV_NVDLA_SDP_RDMA_SPLIT -- requirements
Module: NV_NVDLA_SDP_RDMA_split

---
 rtl/nv_nvdla_sdp_split_pkg.sv | 16 +
 rtl/nv_nvdla_sdp_rdma_split_skid.sv | 41 ++++
 rtl/nv_nvdla_sdp_rdma_split.sv | 112 +++++++++++
 tb/tb_nv_nvdla_sdp_rdma_split.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_split_pkg.sv
// Shared constants for the SDP RDMA word splitter: counter width, FSM encoding, legal ratios.
package nv_nvdla_sdp_split_pkg;

  localparam int unsigned CntW = 4;

  typedef enum logic {
    StEmpty = 1'b0,
    StBusy  = 1'b1
  } split_state_e;

  // Beats-per-word in 16-bit mode; 8-bit mode doubles it, so 8 is the most a 4-bit counter allows.
  function automatic bit ratio_legal(input int unsigned ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_split_skid.sv
// One-entry skid buffer with a registered ready; bypasses straight through when empty.
module nv_nvdla_sdp_rdma_split_skid #(
  parameter int unsigned W = 513
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         full_q, full_d;
  logic [W-1:0] hold_q;

  assign in_rdy   = ~full_q;
  assign out_vld  = full_q | in_vld;
  assign out_data = full_q ? hold_q : in_data;

  always_comb begin
    full_d = full_q;
    if (full_q) begin
      if (out_rdy) full_d = 1'b0;
    end else if (in_vld && !out_rdy) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else begin
      full_q <= full_d;
      if (!full_q && in_vld && !out_rdy) hold_q <= in_data;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_split.sv
// Splits IW-bit read words into OW-bit beats (16-bit mode) or zero-padded half beats (8-bit mode).
// Define NVDLA_SDP_SPLIT_RDY_REG_EN to register inp_prdy through a skid buffer.
module nv_nvdla_sdp_rdma_split
  import nv_nvdla_sdp_split_pkg::*;
#(
  parameter int unsigned IW    = 512,
  parameter int unsigned OW    = 256,
  parameter int unsigned RATIO = IW / OW
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          cfg_dp_8,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [IW-1:0] inp_data,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [OW-1:0] out_data,
  output logic          out_last
);

  localparam logic [CntW-1:0] Last16 = CntW'(RATIO - 1);
  localparam logic [CntW-1:0] Last8  = CntW'(2 * RATIO - 1);

  split_state_e    state_q, state_d;
  logic [IW-1:0]   word_q;
  logic            dp8_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            ld_vld, ld_rdy, ld_take, ld_dp8;
  logic [IW-1:0]   ld_data;
  logic            beat;
  logic [CntW-1:0] last_cnt;

  assign last_cnt = dp8_q ? Last8 : Last16;
  assign out_pvld = (state_q == StBusy);
  assign out_last = out_pvld & (cnt_q == last_cnt);
  assign beat     = out_pvld & out_prdy;
  assign ld_rdy   = (state_q == StEmpty) | (out_prdy & out_last);
  assign ld_take  = ld_vld & ld_rdy;

`ifdef NVDLA_SDP_SPLIT_RDY_REG_EN
  logic [IW:0] skid_data;

  nv_nvdla_sdp_rdma_split_skid #(
    .W(IW + 1)
  ) u_skid (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .in_vld  (inp_pvld),
    .in_rdy  (inp_prdy),
    .in_data ({cfg_dp_8, inp_data}),
    .out_vld (ld_vld),
    .out_rdy (ld_rdy),
    .out_data(skid_data)
  );

  assign {ld_dp8, ld_data} = skid_data;
`else
  assign ld_vld   = inp_pvld;
  assign ld_data  = inp_data;
  assign ld_dp8   = cfg_dp_8;
  assign inp_prdy = ld_rdy;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (beat) cnt_d = out_last ? '0 : cnt_q + 1'b1;
    if (ld_take) begin
      state_d = StBusy;
    end else if (beat && out_last) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      word_q  <= '0;
      dp8_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_take) begin
        word_q <= ld_data;
        dp8_q  <= ld_dp8;
      end
    end
  end

  // Beat tables padded to the full counter range so cnt_q indexes them without width games.
  logic [OW-1:0]   beat16 [16];
  logic [OW/2-1:0] beat8  [16];

  for (genvar k = 0; k < 16; k++) begin : g_beat
    if (k < RATIO) begin : g_w
      assign beat16[k] = word_q[k*OW +: OW];
    end else begin : g_z
      assign beat16[k] = '0;
    end
    if (k < 2 * RATIO) begin : g_h
      assign beat8[k] = word_q[k*(OW/2) +: OW/2];
    end else begin : g_hz
      assign beat8[k] = '0;
    end
  end

  assign out_data = dp8_q ? {{(OW/2){1'b0}}, beat8[cnt_q]} : beat16[cnt_q];

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_split.sv
// Directed bench for nv_nvdla_sdp_rdma_split at IW=512, OW=256.
module tb_nv_nvdla_sdp_rdma_split;

  localparam int unsigned IW = 512;
  localparam int unsigned OW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_dp_8;
  logic          inp_pvld;
  logic          inp_prdy;
  logic [IW-1:0] inp_data;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic          out_last;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_rdma_split #(
    .IW   (IW),
    .OW   (OW),
    .RATIO(2)
  ) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .cfg_dp_8      (cfg_dp_8),
    .inp_pvld      (inp_pvld),
    .inp_prdy      (inp_prdy),
    .inp_data      (inp_data),
    .out_pvld      (out_pvld),
    .out_prdy      (out_prdy),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] ext(input logic b);
    return {{(OW-1){1'b0}}, b};
  endfunction

  function automatic logic [OW-1:0] half(input logic [7:0] b);
    return {32{b}};
  endfunction

  // Offer one word until accepted, then scramble inp_data while not valid.
  task automatic push(input logic [IW-1:0] w, input logic d8);
    bit acc = 0;
    inp_pvld = 1'b1;
    inp_data = w;
    cfg_dp_8 = d8;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (inp_prdy) begin
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("accept", ext(acc), ext(1'b1));
    @(posedge clk); #1;
    inp_pvld = 1'b0;
    inp_data = {16{$urandom()}};
  endtask

  task automatic expect_beat(input string tag, input logic [OW-1:0] d, input logic l);
    @(negedge clk);
    chk({tag, "_vld"}, ext(out_pvld), ext(1'b1));
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, ext(out_last), ext(l));
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk(tag, ext(out_pvld), ext(1'b0));
  endtask

  logic [IW-1:0] w;
  logic [OW-1:0] exp_d;
  logic [OW-1:0] lo [3];
  logic [OW-1:0] hi [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    cfg_dp_8 = 1'b0;
    inp_pvld = 1'b0;
    inp_data = '0;
    out_prdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pvld", ext(out_pvld), ext(1'b0));
    chk("rst_last", ext(out_last), ext(1'b0));
    chk("rst_data", out_data, '0);
    chk("rst_prdy", ext(inp_prdy), ext(1'b1));
    @(posedge clk); #1;

    // 16-bit mode: A-half then B-half
    push({half(8'hBB), half(8'hAA)}, 1'b0);
    expect_beat("m16_b0", half(8'hAA), 1'b0);
    expect_beat("m16_b1", half(8'hBB), 1'b1);
    expect_idle("m16_idle");
    @(posedge clk); #1;

    // 8-bit mode: byte-index pattern, four zero-padded beats
    for (int i = 0; i < 64; i++) w[i*8 +: 8] = 8'(i);
    push(w, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_d = '0;
      exp_d[127:0] = w[k*128 +: 128];
      expect_beat($sformatf("m8_b%0d", k), exp_d, k == 3);
    end
    expect_idle("m8_idle");
    @(posedge clk); #1;

    // Three back-to-back words, one beat per cycle
    for (int i = 0; i < 3; i++) begin
      lo[i] = half(8'(8'h10 + 2 * i));
      hi[i] = half(8'(8'h11 + 2 * i));
    end
    cfg_dp_8 = 1'b0;
    begin
      int sent = 0;
      bit hs;
      for (int n = 0; n < 8; n++) begin
        inp_pvld = (sent < 3);
        if (sent < 3) inp_data = {hi[sent], lo[sent]};
        @(negedge clk);
        if (n >= 1 && n <= 6) begin
          chk($sformatf("b2b_vld%0d", n - 1), ext(out_pvld), ext(1'b1));
          chk($sformatf("b2b_data%0d", n - 1), out_data,
              ((n - 1) % 2 == 0) ? lo[(n - 1) / 2] : hi[(n - 1) / 2]);
          chk($sformatf("b2b_last%0d", n - 1), ext(out_last), ext((n - 1) % 2 == 1));
`ifndef NVDLA_SDP_SPLIT_RDY_REG_EN
          if (out_last) chk($sformatf("b2b_prdy%0d", n - 1), ext(inp_prdy), ext(1'b1));
`endif
        end
        if (n == 7) chk("b2b_idle", ext(out_pvld), ext(1'b0));
        hs = inp_pvld & inp_prdy;
        @(posedge clk); #1;
        if (hs) sent++;
      end
      inp_pvld = 1'b0;
      chk("b2b_sent", ext(sent == 3), ext(1'b1));
    end

    // Back-pressure held for 5 cycles on beat 1
    push({half(8'h5A), half(8'hA5)}, 1'b0);
    expect_beat("stall_b0", half(8'hA5), 1'b0);
    out_prdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_vld%0d", i), ext(out_pvld), ext(1'b1));
      chk($sformatf("stall_data%0d", i), out_data, half(8'h5A));
      chk($sformatf("stall_last%0d", i), ext(out_last), ext(1'b1));
`ifndef NVDLA_SDP_SPLIT_RDY_REG_EN
      chk($sformatf("stall_prdy%0d", i), ext(inp_prdy), ext(1'b0));
`endif
      @(posedge clk); #1;
    end
    out_prdy = 1'b1;
    expect_beat("stall_b1", half(8'h5A), 1'b1);
    expect_idle("stall_idle");
    @(posedge clk); #1;

    // cfg_dp_8 flips mid-word: current word keeps 16-bit framing
    push({half(8'h22), half(8'h33)}, 1'b0);
    expect_beat("cfg_b0", half(8'h33), 1'b0);
    cfg_dp_8 = 1'b1;
    expect_beat("cfg_b1", half(8'h22), 1'b1);
    expect_idle("cfg_idle");
    @(posedge clk); #1;
    w = {half(8'h44), half(8'h66)};
    push(w, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_d = '0;
      exp_d[127:0] = w[k*128 +: 128];
      expect_beat($sformatf("cfg8_b%0d", k), exp_d, k == 3);
    end
    expect_idle("cfg8_idle");
    @(posedge clk); #1;

    // Reset at beat 1 of 4: nothing of that word may survive
    push({half(8'h77), half(8'h88)}, 1'b1);
    exp_d = '0;
    exp_d[127:0] = {16{8'h88}};
    expect_beat("rst_mid_b0", exp_d, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_pvld", ext(out_pvld), ext(1'b0));
    chk("rst_mid_last", ext(out_last), ext(1'b0));
    chk("rst_mid_data", out_data, '0);
    chk("rst_mid_prdy", ext(inp_prdy), ext(1'b1));
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      expect_idle($sformatf("rst_mid_idle%0d", i));
      @(posedge clk); #1;
    end
    // Counter must restart at beat 0
    push({half(8'h99), half(8'hCC)}, 1'b0);
    expect_beat("post_rst_b0", half(8'hCC), 1'b0);
    expect_beat("post_rst_b1", half(8'h99), 1'b1);
    expect_idle("post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
